rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ producers (ALU, load unit, move unit, ...) using round-robin arbitration.
- The register file commits on the rising edge of WriteEnable. This block therefore sequences every write as SETUP (address/data stable, WriteEnable low) then STROBE (WriteEnable high).
- It exports a per-register pending scoreboard so issue logic can stall on in-flight writes.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8)
- ADDR_W, 4, register address width (register count = 2**ADDR_W)
- DATA_W, 16, register data width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester write request, level, held until granted
- req_addr  input  NUM_REQ*ADDR_W  flattened target addresses, requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  flattened write data, requester i at bits [i*DATA_W +: DATA_W]
- gnt  output  NUM_REQ  one-hot grant, combinational, at most one bit high
- WriteEnable  output  1  register-file write strobe, registered
- writeAddr  output  ADDR_W  register-file write address, registered
- writedata  output  DATA_W  register-file write data, registered
- pending  output  2**ADDR_W  bit r high while a captured write to register r is not yet strobed
- busy  output  1  high in SETUP or STROBE

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - WriteEnable=0, writeAddr=0, writedata=0, pending=0, busy=0.
  - State=IDLE.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- State machine has three states: IDLE, SETUP, STROBE.
  - Arbitration window is IDLE or STROBE. In a window with any req high, gnt goes to the first requester set at or after index (last+1) mod NUM_REQ, searching upward with wrap.
  - The grant cycle captures that requester's addr/data into writeAddr/writedata, updates last to the granted index, and sets pending[addr].
  - IDLE: req none -> IDLE; granted -> SETUP.
  - SETUP: WriteEnable=0, address/data stable, no grant -> STROBE.
  - STROBE: WriteEnable=1; pending[writeAddr] clears at the end of this cycle. Granted -> SETUP; otherwise -> IDLE.
- gnt is 0 in SETUP and in any cycle with rst high.
- Requester handshake: drop or replace req/addr/data the cycle after gnt. Values are sampled only in the gnt cycle.
- Latency: req seen in IDLE at cycle t gives gnt at t, SETUP at t+1, and WriteEnable high at t+2. Peak throughput is one write per 2 cycles.
- WriteEnable never stays high two consecutive cycles, so every write produces a fresh rising edge.
- writeAddr/writedata hold their last value in IDLE.
- Simultaneous pending set and clear in STROBE:
  - Clear applies to the old writeAddr, set to the new addr.
  - Same address: bit stays 1.
- Two requesters may target the same register. Writes are serialized in grant order, with no merging or dropping, and the last granted wins.
- Reset mid-operation:
  - Reset in SETUP cancels the write.
  - Reset in STROBE drops WriteEnable next cycle; the write has already committed.
  - pending clears in both cases.
- Grants with req low are impossible. X on unrequested data lanes is ignored.

Optional Feature:
- Macro: RF_ZERO_REG_EN
- Defined: register 0 is hard-zero.
  - A granted request with addr 0 is accepted: gnt pulses and last updates.
  - It produces no SETUP/STROBE and does not set pending[0]. The state stays or returns to IDLE.
  - writeAddr/writedata are not updated for it.
- Undefined: address 0 is written like any other register.

Test Plan:
- Reset then single req[1] with addr=5, data=16'hABCD in IDLE:
  - gnt=3'b010 same cycle.
  - Next cycle WriteEnable=0 with writeAddr=5, writedata=16'hABCD, pending[5]=1.
  - Following cycle WriteEnable=1.
  - After it, pending=0 and state IDLE.
- req=3'b111 held continuously after reset (each requester re-asserts after its grant):
  - Grants in order 0,1,2,0 at 2-cycle spacing.
  - WriteEnable pattern 0,1,0,1,...; never two 1s in a row.
- req[0] and req[2] both target addr 7 with data 16'h0001 / 16'h0002:
  - Two strobes in grant order; last writedata = 16'h0002.
  - pending[7] stays 1 continuously until the final STROBE ends.
- New grant to addr 3 during STROBE of addr 9:
  - In that cycle, pending[9] clears and pending[3] sets.
  - Next cycle WriteEnable=0 with writeAddr=3.
- Reset mid-operation:
  - rst in SETUP: WriteEnable stays 0, pending=0, state IDLE, last=NUM_REQ-1.
  - rst in STROBE: WriteEnable=0 next cycle.
- Compile-time option, req[0] addr=0:
  - With RF_ZERO_REG_EN: gnt=3'b001 and no WriteEnable pulse within 4 cycles.
  - Without it: normal write to register 0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter for a single register-file write port.
// Each write is sequenced as SETUP (address/data stable, WriteEnable low) then
// STROBE (WriteEnable high), so the register file sees a fresh rising edge
// per write. A per-register pending scoreboard tracks captured, unstrobed writes.
// Optional macro RF_ZERO_REG_EN: register 0 is hard-zero, and writes to it are
// granted but dropped.
module rf_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      WriteEnable,
    output logic [ADDR_W-1:0]         writeAddr,
    output logic [DATA_W-1:0]         writedata,
    output logic [2**ADDR_W-1:0]      pending,
    output logic                      busy
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

    state_t              state, state_n;
    logic [IW-1:0]       last, gidx, idx;
    logic                found, accept, win;
    logic [ADDR_W-1:0]   gaddr;
    logic [DATA_W-1:0]   gdata;
    logic [2**ADDR_W-1:0] pend_n;

    assign win   = !rst && (state == IDLE || state == STROBE);
    assign gaddr = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
    assign gdata = req_data[int'(gidx)*DATA_W +: DATA_W];

`ifdef RF_ZERO_REG_EN
    assign accept = found && (gaddr != '0);
`else
    assign accept = found;
`endif

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt   = '0;
        gidx  = last;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last) + i) % NUM_REQ);
            if (win && !found && req[idx]) begin
                found    = 1'b1;
                gidx     = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    // Next state plus scoreboard update: clear the strobed register, then set the newly captured one.
    always_comb begin
        state_n = state;
        pend_n  = pending;
        if (state == STROBE) pend_n[writeAddr] = 1'b0;
        if (accept) pend_n[gaddr] = 1'b1;
        case (state)
            IDLE:    state_n = accept ? SETUP : IDLE;
            SETUP:   state_n = STROBE;
            STROBE:  state_n = accept ? SETUP : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, pointer, registered write port and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= IW'(NUM_REQ - 1);
            WriteEnable <= 1'b0;
            writeAddr   <= '0;
            writedata   <= '0;
            pending     <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            WriteEnable <= (state_n == STROBE);
            busy        <= (state_n != IDLE);
            pending     <= pend_n;
            if (found) last <= gidx;
            if (accept) begin
                writeAddr <= gaddr;
                writedata <= gdata;
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [11:0] req_addr = '0;
    logic [47:0] req_data = '0;
    logic [2:0]  gnt;
    logic        WriteEnable;
    logic [3:0]  writeAddr;
    logic [15:0] writedata;
    logic [15:0] pending;
    logic        busy;
    int checks = 0;
    int errors = 0;

    rf_write_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .WriteEnable(WriteEnable), .writeAddr(writeAddr),
        .writedata(writedata), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [3:0] a, input logic [15:0] d);
        req_addr[i*4 +: 4]   = a;
        req_data[i*16 +: 16] = d;
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        req = 3'b111;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", gnt, 3'b000); end
        checks++; if (WriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", WriteEnable); end
        checks++; if (writeAddr !== 4'd0 || writedata !== 16'h0) begin errors++; $display("FAIL reset_addr_data: got %h/%h expected 0/0000", writeAddr, writedata); end
        checks++; if (pending !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL reset_pend_busy: got %h/%b expected 0000/0", pending, busy); end
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        set_lane(1, 4'd5, 16'hABCD);
        req = 3'b010;
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL single_gnt: got %b expected %b", gnt, 3'b010); end
        tick();
        req = '0;
        #1;
        checks++; if (WriteEnable !== 1'b0 || writeAddr !== 4'd5 || writedata !== 16'hABCD) begin errors++; $display("FAIL single_setup: got we=%b addr=%h data=%h expected 0/5/abcd", WriteEnable, writeAddr, writedata); end
        checks++; if (pending !== 16'h0020 || busy !== 1'b1 || gnt !== 3'b000) begin errors++; $display("FAIL single_setup_pend: got pend=%h busy=%b gnt=%b expected 0020/1/000", pending, busy, gnt); end
        tick();
        checks++; if (WriteEnable !== 1'b1) begin errors++; $display("FAIL single_strobe: got %b expected 1", WriteEnable); end
        tick();
        checks++; if (WriteEnable !== 1'b0 || pending !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got we=%b pend=%h busy=%b expected 0/0000/0", WriteEnable, pending, busy); end
        checks++; if (writeAddr !== 4'd5 || writedata !== 16'hABCD) begin errors++; $display("FAIL single_hold: got %h/%h expected 5/abcd", writeAddr, writedata); end
    endtask

    task automatic test_round_robin();
        logic prev_we;
        logic [2:0] exp_gnt;
        do_reset();
        for (int i = 0; i < 3; i++) set_lane(i, 4'(i + 1), 16'(16'h1000 * (i + 1)));
        req = 3'b111;
        prev_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_gnt = (k % 2 == 0) ? 3'(1 << ((k / 2) % 3)) : 3'b000;
            checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt); end
            checks++; if (WriteEnable !== (k >= 2 && k % 2 == 0)) begin errors++; $display("FAIL rr_we[%0d]: got %b expected %b", k, WriteEnable, (k >= 2 && k % 2 == 0)); end
            checks++; if (prev_we && WriteEnable) begin errors++; $display("FAIL rr_we_double[%0d]: got 1,1 expected no consecutive highs", k); end
            prev_we = WriteEnable;
            tick();
        end
        req = '0;
        tick();
        tick();
        checks++; if (pending !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got %h/%b expected 0000/0", pending, busy); end
    endtask

    task automatic test_same_addr();
        do_reset();
        set_lane(0, 4'd7, 16'h0001);
        set_lane(2, 4'd7, 16'h0002);
        req = 3'b101;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL same_gnt0: got %b expected 001", gnt); end
        tick();
        req = 3'b100;
        checks++; if (pending[7] !== 1'b1 || writedata !== 16'h0001) begin errors++; $display("FAIL same_setup0: got p7=%b data=%h expected 1/0001", pending[7], writedata); end
        tick();
        checks++; if (gnt !== 3'b100 || WriteEnable !== 1'b1) begin errors++; $display("FAIL same_strobe0: got gnt=%b we=%b expected 100/1", gnt, WriteEnable); end
        tick();
        req = '0;
        checks++; if (pending[7] !== 1'b1 || writedata !== 16'h0002 || WriteEnable !== 1'b0) begin errors++; $display("FAIL same_setup1: got p7=%b data=%h we=%b expected 1/0002/0", pending[7], writedata, WriteEnable); end
        tick();
        checks++; if (pending[7] !== 1'b1 || WriteEnable !== 1'b1 || writedata !== 16'h0002) begin errors++; $display("FAIL same_strobe1: got p7=%b we=%b data=%h expected 1/1/0002", pending[7], WriteEnable, writedata); end
        tick();
        checks++; if (pending !== 16'h0 || writedata !== 16'h0002) begin errors++; $display("FAIL same_done: got pend=%h data=%h expected 0000/0002", pending, writedata); end
    endtask

    task automatic test_overlap();
        do_reset();
        set_lane(0, 4'd9, 16'h0909);
        req = 3'b001;
        tick();
        req = '0;
        tick();
        set_lane(1, 4'd3, 16'h0303);
        req = 3'b010;
        #1;
        checks++; if (gnt !== 3'b010 || WriteEnable !== 1'b1 || writeAddr !== 4'd9) begin errors++; $display("FAIL ovl_strobe: got gnt=%b we=%b addr=%h expected 010/1/9", gnt, WriteEnable, writeAddr); end
        checks++; if (pending !== 16'h0200) begin errors++; $display("FAIL ovl_pend_before: got %h expected 0200", pending); end
        tick();
        req = '0;
        checks++; if (pending !== 16'h0008 || WriteEnable !== 1'b0 || writeAddr !== 4'd3 || writedata !== 16'h0303) begin errors++; $display("FAIL ovl_after: got pend=%h we=%b addr=%h data=%h expected 0008/0/3/0303", pending, WriteEnable, writeAddr, writedata); end
        tick();
        tick();
        checks++; if (pending !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL ovl_done: got %h/%b expected 0000/0", pending, busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_lane(0, 4'd4, 16'h4444);
        req = 3'b001;
        tick();
        req = 3'b000;
        rst = 1'b1;
        tick();
        checks++; if (WriteEnable !== 1'b0 || pending !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL rst_setup: got we=%b pend=%h busy=%b expected 0/0000/0", WriteEnable, pending, busy); end
        rst = 1'b0;
        tick();
        checks++; if (WriteEnable !== 1'b0) begin errors++; $display("FAIL rst_setup_we: got %b expected 0", WriteEnable); end
        req = 3'b111;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rst_setup_last: got %b expected 001", gnt); end
        tick();
        req = '0;
        tick();
        checks++; if (WriteEnable !== 1'b1 || pending !== 16'h0010) begin errors++; $display("FAIL rst_strobe_pre: got we=%b pend=%h expected 1/0010", WriteEnable, pending); end
        rst = 1'b1;
        tick();
        checks++; if (WriteEnable !== 1'b0 || pending !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL rst_strobe: got we=%b pend=%h busy=%b expected 0/0000/0", WriteEnable, pending, busy); end
        rst = 1'b0;
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_lane(0, 4'd0, 16'h5555);
        req = 3'b001;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL zero_gnt: got %b expected 001", gnt); end
        tick();
        req = '0;
`ifdef RF_ZERO_REG_EN
        for (int k = 0; k < 4; k++) begin
            checks++; if (WriteEnable !== 1'b0 || pending !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL zero_drop[%0d]: got we=%b pend=%h busy=%b expected 0/0000/0", k, WriteEnable, pending, busy); end
            tick();
        end
        checks++; if (writedata !== 16'h0) begin errors++; $display("FAIL zero_data: got %h expected 0000", writedata); end
`else
        checks++; if (writeAddr !== 4'd0 || writedata !== 16'h5555 || pending !== 16'h0001) begin errors++; $display("FAIL zero_setup: got addr=%h data=%h pend=%h expected 0/5555/0001", writeAddr, writedata, pending); end
        tick();
        checks++; if (WriteEnable !== 1'b1) begin errors++; $display("FAIL zero_strobe: got %b expected 1", WriteEnable); end
        tick();
        tick();
        checks++; if (WriteEnable !== 1'b0 || pending !== 16'h0) begin errors++; $display("FAIL zero_done: got we=%b pend=%h expected 0/0000", WriteEnable, pending); end
`endif
        req = 3'b011;
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL zero_last: got %b expected 010", gnt); end
        req = '0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_same_addr();
        test_overlap();
        test_reset_mid();
        test_zero_reg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
